// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_pkg : shared transmitter state encoding and line levels.
// Revision : 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      GUARD  = 3'd5
   } tx_state_t;

   localparam logic UART_IDLE_LVL  = 1'b1;
   localparam logic UART_START_LVL = 1'b0;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_fifo : small synchronous FIFO, combinational head read, no bypass.
// Revision     : 1.0
// ----------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_push,
   input  logic [WIDTH-1:0]          i_wdata,
   input  logic                      i_pop,
   output logic [WIDTH-1:0]          o_rdata,
   output logic                      o_full,
   output logic                      o_empty,
   output logic [$clog2(DEPTH):0]    o_level
);

   localparam int                c_aw       = $clog2(DEPTH);
   localparam logic [c_aw:0]     c_full_lvl = DEPTH;
   localparam logic [c_aw:0]     c_lvl_one  = 1;
   localparam logic [c_aw-1:0]   c_ptr_one  = 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_aw-1:0]  r_wr_ptr;
   logic [c_aw-1:0]  r_rd_ptr;
   logic [c_aw:0]    r_level;
   logic             w_push_ok;
   logic             w_pop_ok;

   // A push at full is refused even when a pop frees a slot this cycle.
   assign o_full    = (r_level == c_full_lvl);
   assign o_empty   = (r_level == '0);
   assign w_push_ok = i_push && !o_full;
   assign w_pop_ok  = i_pop && !o_empty;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign o_level   = r_level;

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_level <= r_level + c_lvl_one;
            2'b01:   r_level <= r_level - c_lvl_one;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_engine : FIFO-buffered UART transmitter; parity bit only when
//                  UART_TX_PARITY_EN is defined.
// Revision       : 1.0
// ----------------------------------------------------------------------------
module uart_tx_engine
   import uart_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int CLK_DIV    = 16,
   parameter int STOP_BITS  = 1,
   parameter int GUARD_BITS = 13,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          link_en,
   input  logic [DATA_W-1:0]             s_data,
   input  logic                          s_valid,
   output logic                          s_ready,
`ifdef UART_TX_PARITY_EN
   input  logic                          parity_odd,
`endif
   output logic                          txd,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

`ifdef UART_TX_PARITY_EN
   localparam int c_fifo_w = DATA_W + 1;
`else
   localparam int c_fifo_w = DATA_W;
`endif
   localparam int                  c_div_w    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [c_div_w-1:0]  c_div_last = c_div_w'(CLK_DIV - 1);
   localparam logic [c_div_w-1:0]  c_div_one  = 1;
   localparam int                  c_max_a    = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
   localparam int                  c_max_bits = (c_max_a > GUARD_BITS) ? c_max_a : GUARD_BITS;
   localparam int                  c_bit_w    = $clog2(c_max_bits + 1);
   localparam logic [c_bit_w-1:0]  c_bit_one  = 1;

   tx_state_t             r_state;
   logic [c_div_w-1:0]    r_div;
   logic [c_bit_w-1:0]    r_bit;
   logic [DATA_W-1:0]     r_shift;
   logic                  r_txd;
   logic                  r_busy;
`ifdef UART_TX_PARITY_EN
   logic                  r_par;
`endif

   logic [c_fifo_w-1:0]   w_fifo_wdata;
   logic [c_fifo_w-1:0]   w_fifo_rdata;
   logic                  w_fifo_full;
   logic                  w_fifo_empty;
   logic [c_bit_w-1:0]    w_len;
   logic                  w_div_wrap;
   logic                  w_bit_last;
   logic                  w_frame_end;
   logic                  w_pop;

   // The data parity is folded in on the way in; the odd/even choice is applied at pop.
`ifdef UART_TX_PARITY_EN
   assign w_fifo_wdata = {^s_data, s_data};
`else
   assign w_fifo_wdata = s_data;
`endif

   uart_tx_fifo #(
      .WIDTH (c_fifo_w),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (s_valid),
      .i_wdata (w_fifo_wdata),
      .i_pop   (w_pop),
      .o_rdata (w_fifo_rdata),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_level (fifo_level)
   );

   always_comb begin
      w_len = c_bit_one;
      case (r_state)
         DATA:    w_len = c_bit_w'(DATA_W);
         STOP:    w_len = c_bit_w'(STOP_BITS);
         GUARD:   w_len = c_bit_w'(GUARD_BITS);
         default: w_len = c_bit_one;
      endcase
   end

   assign w_div_wrap  = (r_div == c_div_last);
   assign w_bit_last  = (r_bit == (w_len - c_bit_one));
   assign w_frame_end = w_div_wrap && w_bit_last &&
                        ((r_state == GUARD) || ((r_state == STOP) && (GUARD_BITS == 0)));
   // Popping on the last cycle of a frame lets queued words follow with no gap.
   assign w_pop       = link_en && !w_fifo_empty && ((r_state == IDLE) || w_frame_end);

   always_ff @(posedge clk) begin
      if (rst || !link_en) begin
         r_state <= IDLE;
         r_div   <= '0;
         r_bit   <= '0;
         r_txd   <= UART_IDLE_LVL;
         r_busy  <= 1'b0;
      end else if (w_pop) begin
         r_state <= START;
         r_div   <= '0;
         r_bit   <= '0;
         r_txd   <= UART_START_LVL;
         r_busy  <= 1'b1;
         r_shift <= w_fifo_rdata[DATA_W-1:0];
`ifdef UART_TX_PARITY_EN
         r_par   <= w_fifo_rdata[DATA_W] ^ parity_odd;
`endif
      end else if (w_frame_end) begin
         r_state <= IDLE;
         r_div   <= '0;
         r_bit   <= '0;
         r_txd   <= UART_IDLE_LVL;
         r_busy  <= 1'b0;
      end else if (r_state != IDLE) begin
         if (!w_div_wrap) begin
            r_div <= r_div + c_div_one;
         end else begin
            r_div <= '0;
            if (!w_bit_last) begin
               r_bit <= r_bit + c_bit_one;
               if (r_state == DATA) begin
                  r_shift <= r_shift >> 1;
                  r_txd   <= r_shift[1];
               end
            end else begin
               r_bit <= '0;
               case (r_state)
                  START: begin
                     r_state <= DATA;
                     r_txd   <= r_shift[0];
                  end
                  DATA: begin
`ifdef UART_TX_PARITY_EN
                     r_state <= PARITY;
                     r_txd   <= r_par;
`else
                     r_state <= STOP;
                     r_txd   <= UART_IDLE_LVL;
`endif
                  end
                  PARITY: begin
                     r_state <= STOP;
                     r_txd   <= UART_IDLE_LVL;
                  end
                  STOP: begin
                     r_state <= GUARD;
                     r_txd   <= UART_IDLE_LVL;
                  end
                  default: begin
                     r_state <= IDLE;
                     r_txd   <= UART_IDLE_LVL;
                     r_busy  <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

   assign s_ready = !w_fifo_full;
   assign txd     = r_txd;
   assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_tx_engine : directed frame table and sequences on dut0, randomized
//                     traffic on dut1 against a frame-level reference model.
// Revision          : 1.0
// ----------------------------------------------------------------------------
module tb_uart_tx_engine;

`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int DIV0 = 4;
   localparam int NB0  = 1 + 8 + P + 1;
   localparam int DIV1 = 3;
   localparam int NB1  = 1 + 8 + P + 2 + 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       link_en0 = 1'b1, s_valid0 = 1'b0, s_ready0, txd0, busy0;
   logic [7:0] s_data0 = '0;
   logic [2:0] level0;
   logic       link_en1 = 1'b1, s_valid1 = 1'b0, s_ready1, txd1, busy1;
   logic [7:0] s_data1 = '0;
   logic [2:0] level1;
`ifdef UART_TX_PARITY_EN
   logic       parity_odd0 = 1'b0, parity_odd1 = 1'b0;
`endif

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   uart_tx_engine #(.DATA_W(8), .CLK_DIV(DIV0), .STOP_BITS(1), .GUARD_BITS(0), .FIFO_DEPTH(4)) u_dut0 (
      .clk(clk), .rst(rst), .link_en(link_en0), .s_data(s_data0), .s_valid(s_valid0), .s_ready(s_ready0),
`ifdef UART_TX_PARITY_EN
      .parity_odd(parity_odd0),
`endif
      .txd(txd0), .busy(busy0), .fifo_level(level0));

   uart_tx_engine #(.DATA_W(8), .CLK_DIV(DIV1), .STOP_BITS(2), .GUARD_BITS(2), .FIFO_DEPTH(4)) u_dut1 (
      .clk(clk), .rst(rst), .link_en(link_en1), .s_data(s_data1), .s_valid(s_valid1), .s_ready(s_ready1),
`ifdef UART_TX_PARITY_EN
      .parity_odd(parity_odd1),
`endif
      .txd(txd1), .busy(busy1), .fifo_level(level1));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Expected line level per bit period of one frame (index 0 = start bit).
   function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic par);
      logic [10:0] b;
      b = '1;
      b[0] = 1'b0;
      for (int i = 0; i < 8; i++) b[1 + i] = d[i];
      if (P == 1) b[9] = par;
      return b;
   endfunction

   // Called just before the pop edge; walks every clk of the frame on dut0.
   task automatic check_frame(input string nm, input logic [10:0] bits, input int lvl);
      for (int k = 0; k < NB0 * DIV0; k++) begin
         @(negedge clk);
         chk($sformatf("%s_txd_c%0d", nm, k), txd0, bits[k / DIV0]);
         if (k % DIV0 == 0) chk($sformatf("%s_busy_c%0d", nm, k), busy0, 1);
         if (k == 0) chk({nm, "_level"}, level0, lvl);
      end
   endtask

   task automatic check_idle0(input string nm, input int lvl);
      chk({nm, "_txd"}, txd0, 1);
      chk({nm, "_busy"}, busy0, 0);
      chk({nm, "_level"}, level0, lvl);
   endtask

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;
      logic       par;
   } vec_t;

   vec_t        tbl [6];
   logic [7:0]  wds [5];
   logic [10:0] fb;

   // Reference model state for dut1
   logic [7:0]  m_q [$];
   bit          m_active;
   int          m_t;
   logic        m_bits [16];
   logic        m_txd;
   bit          m_acc;
   int          lo_cnt;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{8'hA5, 10'b1101001010, 1'b0};
      tbl[1] = '{8'h00, 10'b1000000000, 1'b0};
      tbl[2] = '{8'hFF, 10'b1111111110, 1'b0};
      tbl[3] = '{8'h01, 10'b1000000010, 1'b1};
      tbl[4] = '{8'h80, 10'b1100000000, 1'b1};
      tbl[5] = '{8'h3C, 10'b1001111000, 1'b0};
      wds = '{8'h5A, 8'hC3, 8'h0F, 8'h96, 8'hEE};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle0("rst0", 0);
      chk("rst0_s_ready", s_ready0, 1);
      chk("rst1_txd", txd1, 1);
      chk("rst1_busy", busy1, 0);
      chk("rst1_level", level1, 0);
      chk("rst1_s_ready", s_ready1, 1);
      rst = 1'b0;

      // Table: single words, first start bit one clk after the accepting edge's follower
      for (int i = 0; i < 6; i++) begin
`ifdef UART_TX_PARITY_EN
         fb = {1'b1, tbl[i].par, tbl[i].frame[8:0]};
`else
         fb = {1'b1, tbl[i].frame};
`endif
         s_valid0 = 1'b1;
         s_data0  = tbl[i].data;
         @(negedge clk);
         s_valid0 = 1'b0;
         check_idle0($sformatf("tbl%0d_pre", i), 1);
         check_frame($sformatf("tbl%0d", i), fb, 0);
         @(negedge clk);
         check_idle0($sformatf("tbl%0d_post", i), 0);
      end

      // Fill with link down: fifth push refused
      link_en0 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         s_valid0 = 1'b1;
         s_data0  = wds[i];
         @(negedge clk);
         chk($sformatf("fill%0d_level", i), level0, (i < 4) ? i + 1 : 4);
         chk($sformatf("fill%0d_ready", i), s_ready0, (i < 3) ? 1 : 0);
      end
      s_valid0 = 1'b0;
      check_idle0("fill_idle", 4);

      // Link up: four frames back-to-back, in push order
      link_en0 = 1'b1;
      for (int i = 0; i < 4; i++)
         check_frame($sformatf("b2b%0d", i), frame_bits(wds[i], ^wds[i]), 3 - i);
      @(negedge clk);
      check_idle0("b2b_post", 0);

      // Link dropped during data bit 3
      s_valid0 = 1'b1;
      s_data0  = 8'h69;
      @(negedge clk);
      chk("drop_pre_txd", txd0, 1);
      s_data0 = 8'h2D;
      @(negedge clk);
      s_valid0 = 1'b0;
      fb = frame_bits(8'h69, ^8'h69);
      chk("drop_start_txd", txd0, 0);
      chk("drop_start_level", level0, 1);
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         chk($sformatf("drop_txd_c%0d", k), txd0, fb[k / DIV0]);
      end
      link_en0 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_idle0($sformatf("drop_down%0d", k), 1);
      end
      link_en0 = 1'b1;
      check_frame("drop_next", frame_bits(8'h2D, ^8'h2D), 0);
      @(negedge clk);
      check_idle0("drop_post", 0);

`ifdef UART_TX_PARITY_EN
      parity_odd0 = 1'b0;
      s_valid0 = 1'b1;
      s_data0  = 8'h07;
      @(negedge clk);
      s_valid0 = 1'b0;
      check_frame("par_even", frame_bits(8'h07, 1'b1), 0);
      @(negedge clk);
      parity_odd0 = 1'b1;
      s_valid0 = 1'b1;
      @(negedge clk);
      s_valid0 = 1'b0;
      check_frame("par_odd", frame_bits(8'h07, 1'b0), 0);
      @(negedge clk);
      check_idle0("par_post", 0);
      parity_odd0 = 1'b0;
`endif

      // Reset inside the stop bit with two words queued
      s_valid0 = 1'b1;
      s_data0  = 8'hA1;
      @(negedge clk);
      s_data0 = 8'hB2;
      @(negedge clk);
      s_data0 = 8'hC3;
      @(negedge clk);
      s_valid0 = 1'b0;
      chk("rstmid_level", level0, 2);
      for (int t = 2; t <= 37 + 4 * P; t++) @(negedge clk);
      chk("rstmid_stop_txd", txd0, 1);
      chk("rstmid_stop_busy", busy0, 1);
      rst = 1'b1;
      @(negedge clk);
      check_idle0("rstmid_after", 0);
      chk("rstmid_ready", s_ready0, 1);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check_idle0($sformatf("rstmid_hold%0d", k), 0);
      end

      // Randomized traffic on dut1 against the frame-level model
      m_active = 0;
      m_t      = 0;
      m_txd    = 1'b1;
      m_acc    = 0;
      lo_cnt   = 0;
      for (int c = 0; c < 4000; c++) begin
         chk($sformatf("rnd_txd_c%0d", c), txd1, m_txd);
         chk($sformatf("rnd_busy_c%0d", c), busy1, m_active);
         chk($sformatf("rnd_level_c%0d", c), level1, m_q.size());
         chk($sformatf("rnd_ready_c%0d", c), s_ready1, (m_q.size() < 4) ? 1 : 0);
         if (!s_valid1 || m_acc) begin
            s_valid1 = (c < 2000) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 39) == 0);
            s_data1  = 8'($urandom);
         end
         if (lo_cnt > 0) begin
            lo_cnt--;
            link_en1 = 1'b0;
         end else if ($urandom_range(0, 299) == 0) begin
            lo_cnt   = $urandom_range(0, 15);
            link_en1 = 1'b0;
         end else begin
            link_en1 = 1'b1;
         end
`ifdef UART_TX_PARITY_EN
         parity_odd1 = 1'($urandom);
`endif
         @(posedge clk);
         m_acc = s_valid1 && (m_q.size() < 4);
         if (!link_en1) begin
            m_active = 0;
         end else begin
            if (m_active) begin
               m_t++;
               if (m_t == NB1 * DIV1) m_active = 0;
            end
            if (!m_active && m_q.size() > 0) begin
               logic [7:0] d;
               d = m_q.pop_front();
               for (int i = 0; i < 16; i++) m_bits[i] = 1'b1;
               m_bits[0] = 1'b0;
               for (int i = 0; i < 8; i++) m_bits[1 + i] = d[i];
`ifdef UART_TX_PARITY_EN
               m_bits[9] = (^d) ^ parity_odd1;
`endif
               m_t      = 0;
               m_active = 1;
            end
         end
         if (m_acc) m_q.push_back(s_data1);
         m_txd = m_active ? m_bits[m_t / DIV1] : 1'b1;
         @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
